// File: rtl/gt0000_ee_pkg.sv
// Shared definitions for the EEPROM power-on configuration loader and the digital top.
package gt0000_ee_pkg;

   localparam int unsigned EE_ADDR_W = 15;
   localparam int unsigned EE_BIT_W  = 3;
   localparam int unsigned EE_OPT_W  = 6;
   localparam int unsigned EE_TR_W   = 8;

   // Config row layout, relative to the base address
   localparam int unsigned CFG_OPT_IDX  = 0;
   localparam int unsigned CFG_OPTN_IDX = 1;
   localparam int unsigned CFG_TR_IDX   = 2;
   localparam int unsigned CFG_BYTES    = 3;
   localparam int unsigned CFG_IDX_W    = 2;

   typedef enum logic [2:0] {
      StIdle,
      StWaitBusy,
      StRead,
      StCheck,
      StDone
   } ld_state_e;

   typedef enum logic [1:0] {
      RdIdle,
      RdSetup,
      RdStrobe
   } rd_state_e;

endpackage

// File: rtl/ee_bit_reader.sv
// Single-bit EEPROM read sequencer: address setup phase followed by the rd_clk strobe phase.
module ee_bit_reader
   import gt0000_ee_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = EE_ADDR_W,
   parameter int unsigned BIT_WIDTH  = EE_BIT_W,
   parameter int unsigned RD_SETUP   = 2,
   parameter int unsigned RD_PULSE   = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [BIT_WIDTH-1:0]  bit_sel_i,
   input  logic                  data_i,
   output logic [ADDR_WIDTH-1:0] ee_addr_o,
   output logic [BIT_WIDTH-1:0]  bit_sel_o,
   output logic                  rd_en_o,
   output logic                  rd_clk_o,
   output logic                  data_vld_o,
   output logic                  data_o
);

   localparam int unsigned CntMax = (RD_SETUP > RD_PULSE) ? RD_SETUP : RD_PULSE;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   rd_state_e             state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BIT_WIDTH-1:0]  sel_q, sel_d;
   logic                  rd_en_q, rd_clk_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      sel_d      = sel_q;
      data_vld_o = 1'b0;
      unique case (state_q)
         RdIdle: ;
         RdSetup: begin
            if (cnt_q == CntW'(RD_SETUP - 1)) begin
               state_d = RdStrobe;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RdStrobe: begin
            if (cnt_q == CntW'(RD_PULSE - 1)) begin
               // The loader samples data_o on the edge that closes the strobe
               data_vld_o = 1'b1;
               state_d    = RdIdle;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RdIdle;
      endcase
      if (start_i) begin
         state_d = RdSetup;
         cnt_d   = '0;
         addr_d  = addr_i;
         sel_d   = bit_sel_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= RdIdle;
         cnt_q    <= '0;
         addr_q   <= '0;
         sel_q    <= '0;
         rd_en_q  <= 1'b0;
         rd_clk_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         sel_q    <= sel_d;
         rd_en_q  <= (state_d != RdIdle);
         rd_clk_q <= (state_d == RdStrobe);
      end
   end

   assign ee_addr_o = addr_q;
   assign bit_sel_o = sel_q;
   assign rd_en_o   = rd_en_q;
   assign rd_clk_o  = rd_clk_q;
   assign data_o    = data_i;

endmodule

// File: rtl/ee_por_cfg_loader.sv
// Power-on config loader: reads option/complement/trim bytes bit-serially, validates, retries,
// falls back to defaults, and commits the result atomically with por_cfg_done.
module ee_por_cfg_loader
   import gt0000_ee_pkg::*;
#(
   parameter int unsigned                EE_ADDR_WIDTH = EE_ADDR_W,
   parameter int unsigned                EE_BIT_WIDTH  = EE_BIT_W,
   parameter int unsigned                EE_OPT_WIDTH  = EE_OPT_W,
   parameter int unsigned                EE_TR_WIDTH   = EE_TR_W,
   parameter logic [EE_ADDR_WIDTH-1:0]   CFG_BASE_ADDR = 15'h7FF8,
   parameter int unsigned                RD_SETUP      = 2,
   parameter int unsigned                RD_PULSE      = 2,
   parameter int unsigned                MAX_RETRY     = 2,
   parameter logic [EE_OPT_WIDTH-1:0]    OPT_DEFAULT   = 6'b000000,
   parameter logic [EE_TR_WIDTH-1:0]     TR_DEFAULT    = 8'h80
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ee_busy,
   input  logic                      cfg_reload,
   input  logic                      ee_data_e2l,
   output logic [EE_ADDR_WIDTH-1:0]  ee_addr,
   output logic [EE_BIT_WIDTH-1:0]   bit_sel,
   output logic                      rd_en,
   output logic                      rd_clk,
   output logic [EE_OPT_WIDTH-1:0]   op,
   output logic [EE_OPT_WIDTH-3:0]   op_n,
   output logic [EE_TR_WIDTH-1:0]    tr,
   output logic                      por_cfg_done,
   output logic                      cfg_err
);

   localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

   ld_state_e                   state_q, state_d;
   logic [CFG_IDX_W-1:0]        byte_idx_q, byte_idx_d;
   logic [EE_BIT_WIDTH-1:0]     bit_idx_q, bit_idx_d;
   logic [RetryW-1:0]           retry_q, retry_d;
   logic [CFG_BYTES-1:0][7:0]   cfg_byte_q, cfg_byte_d;
   logic [EE_OPT_WIDTH-1:0]     op_q, op_d;
   logic [EE_OPT_WIDTH-3:0]     op_n_q, op_n_d;
   logic [EE_TR_WIDTH-1:0]      tr_q, tr_d;
   logic                        err_q, err_d;
   logic                        done_q, done_d;

   logic                        want_bit;
   logic                        rd_start;
   logic                        rd_vld;
   logic                        rd_bit;
   logic                        last_bit;
   logic                        cfg_ok;
   logic [EE_ADDR_WIDTH-1:0]    rd_addr;

   assign last_bit = (byte_idx_q == CFG_IDX_W'(CFG_BYTES - 1)) && (bit_idx_q == '1);
   assign cfg_ok   = (cfg_byte_q[CFG_OPTN_IDX] == ~cfg_byte_q[CFG_OPT_IDX]);
   // The reader latches the index of the bit about to be read, i.e. the post-advance one
   assign rd_addr  = CFG_BASE_ADDR + EE_ADDR_WIDTH'(byte_idx_d);

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      bit_idx_d  = bit_idx_q;
      retry_d    = retry_q;
      cfg_byte_d = cfg_byte_q;
      op_d       = op_q;
      op_n_d     = op_n_q;
      tr_d       = tr_q;
      err_d      = err_q;
      done_d     = done_q;
      want_bit   = 1'b0;
      rd_start   = 1'b0;
      unique case (state_q)
         StIdle: begin
            byte_idx_d = '0;
            bit_idx_d  = '0;
            want_bit   = 1'b1;
         end
         StWaitBusy: want_bit = 1'b1;
         StRead: begin
            if (rd_vld) begin
               cfg_byte_d[byte_idx_q][bit_idx_q] = rd_bit;
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == '1) begin
                  byte_idx_d = byte_idx_q + 1'b1;
               end
               if (last_bit) begin
                  byte_idx_d = '0;
                  state_d    = StCheck;
               end else begin
                  want_bit = 1'b1;
               end
            end
         end
         StCheck: begin
            if (cfg_ok) begin
               op_d    = cfg_byte_q[CFG_OPT_IDX][EE_OPT_WIDTH-1:0];
               op_n_d  = ~cfg_byte_q[CFG_OPT_IDX][EE_OPT_WIDTH-3:0];
               tr_d    = cfg_byte_q[CFG_TR_IDX][EE_TR_WIDTH-1:0];
               err_d   = 1'b0;
               done_d  = 1'b1;
               state_d = StDone;
            end else if (retry_q < RetryW'(MAX_RETRY)) begin
               retry_d  = retry_q + 1'b1;
               want_bit = 1'b1;
            end else begin
               op_d    = OPT_DEFAULT;
               op_n_d  = ~OPT_DEFAULT[EE_OPT_WIDTH-3:0];
               tr_d    = TR_DEFAULT;
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            if (cfg_reload) begin
               done_d     = 1'b0;
               retry_d    = '0;
               byte_idx_d = '0;
               bit_idx_d  = '0;
               state_d    = StWaitBusy;
            end
         end
         default: state_d = StIdle;
      endcase
      // Busy is checked before every bit; an idle EEPROM costs no extra cycle
      if (want_bit) begin
         if (!ee_busy) begin
            rd_start = 1'b1;
            state_d  = StRead;
         end else begin
            state_d = StWaitBusy;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         byte_idx_q <= '0;
         bit_idx_q  <= '0;
         retry_q    <= '0;
         cfg_byte_q <= '0;
         op_q       <= OPT_DEFAULT;
         op_n_q     <= ~OPT_DEFAULT[EE_OPT_WIDTH-3:0];
         tr_q       <= TR_DEFAULT;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         bit_idx_q  <= bit_idx_d;
         retry_q    <= retry_d;
         cfg_byte_q <= cfg_byte_d;
         op_q       <= op_d;
         op_n_q     <= op_n_d;
         tr_q       <= tr_d;
         err_q      <= err_d;
         done_q     <= done_d;
      end
   end

   ee_bit_reader #(
      .ADDR_WIDTH (EE_ADDR_WIDTH),
      .BIT_WIDTH  (EE_BIT_WIDTH),
      .RD_SETUP   (RD_SETUP),
      .RD_PULSE   (RD_PULSE)
   ) u_bit_reader (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (rd_start),
      .addr_i     (rd_addr),
      .bit_sel_i  (bit_idx_d),
      .data_i     (ee_data_e2l),
      .ee_addr_o  (ee_addr),
      .bit_sel_o  (bit_sel),
      .rd_en_o    (rd_en),
      .rd_clk_o   (rd_clk),
      .data_vld_o (rd_vld),
      .data_o     (rd_bit)
   );

   assign op           = op_q;
   assign op_n         = op_n_q;
   assign tr           = tr_q;
   assign cfg_err      = err_q;
   assign por_cfg_done = done_q;

endmodule

// File: tb/tb_ee_por_cfg_loader.sv
// Self-checking bench for ee_por_cfg_loader with a behavioural EEPROM and config-load model.
module tb_ee_por_cfg_loader;

   localparam logic [14:0] BASE      = 15'h7FF8;
   localparam logic [14:0] BASE1     = BASE + 15'd1;
   localparam logic [14:0] BASE2     = BASE + 15'd2;
   localparam int          MAX_RETRY = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ee_busy = 1'b0;
   logic        cfg_reload = 1'b0;
   logic        ee_data;
   logic [14:0] ee_addr;
   logic [2:0]  bit_sel;
   logic        rd_en, rd_clk;
   logic [5:0]  op;
   logic [3:0]  op_n;
   logic [7:0]  tr;
   logic        done, err;

   always #5 clk = ~clk;

   ee_por_cfg_loader u_dut (
      .clk          (clk),
      .rst          (rst),
      .ee_busy      (ee_busy),
      .cfg_reload   (cfg_reload),
      .ee_data_e2l  (ee_data),
      .ee_addr      (ee_addr),
      .bit_sel      (bit_sel),
      .rd_en        (rd_en),
      .rd_clk       (rd_clk),
      .op           (op),
      .op_n         (op_n),
      .tr           (tr),
      .por_cfg_done (done),
      .cfg_err      (err)
   );

   // EEPROM model: config row plus optional byte1 corruption
   logic [7:0] mem [3];
   logic       bad_first = 1'b0;
   logic       bad_all   = 1'b0;
   int         pulse_cnt = 0;
   logic [7:0] rd_byte;

   always_comb begin
      rd_byte = 8'h00;
      if (ee_addr == BASE) rd_byte = mem[0];
      else if (ee_addr == BASE1)
         rd_byte = (bad_all || (bad_first && pulse_cnt <= 24)) ? 8'h00 : mem[1];
      else if (ee_addr == BASE2) rd_byte = mem[2];
      ee_data = rd_en ? rd_byte[bit_sel] : 1'b0;
   end

   int            tests_run = 0;
   int            tests_failed = 0;
   logic [17:0]   strobe_log[$];
   logic          prev_rd_clk;
   int            rd_low;

   task automatic sample();
      if (!rd_en) rd_low++;
      if (rd_clk && !prev_rd_clk) begin
         pulse_cnt++;
         strobe_log.push_back({ee_addr, bit_sel});
      end
      prev_rd_clk = rd_clk;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      ee_busy = 1'b0;
      cfg_reload = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Releases rst and counts edges until por_cfg_done; -1 on timeout
   task automatic run_load(input int busy_at, input int busy_len, input int reload_at,
                           output int cycles);
      cycles = -1;
      rd_low = 0;
      pulse_cnt = 0;
      strobe_log.delete();
      prev_rd_clk = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sample();
      for (int n = 1; n <= 2000; n++) begin
         @(posedge clk);
         #1;
         if (n == busy_at) ee_busy = 1'b1;
         if (n == busy_at + busy_len) ee_busy = 1'b0;
         cfg_reload = (n == reload_at);
         if (done) begin
            cycles = n;
            break;
         end
         sample();
      end
      ee_busy = 1'b0;
      cfg_reload = 1'b0;
   endtask

   task automatic set_mem(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic bf, input logic ba);
      mem[0] = b0;
      mem[1] = b1;
      mem[2] = b2;
      bad_first = bf;
      bad_all = ba;
   endtask

   task automatic test_reset();
      cfg_reload = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cfg_reload = 1'b0;
      tests_run++;
      if ({op, op_n, tr} !== {6'h00, 4'hF, 8'h80}) begin
         tests_failed++;
         $display("FAIL reset_cfg: got op=%h op_n=%h tr=%h, expected 00/f/80", op, op_n, tr);
      end
      tests_run++;
      if ({done, err, rd_en, rd_clk} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags: got done/err/rd_en/rd_clk=%b, expected 0000",
                  {done, err, rd_en, rd_clk});
      end
      tests_run++;
      if ({ee_addr, bit_sel} !== 18'h0) begin
         tests_failed++;
         $display("FAIL reset_addr: got addr=%h bit=%0d, expected 0/0", ee_addr, bit_sel);
      end
   endtask

   task automatic test_power_up();
      int cyc;
      int errs;
      logic [17:0] exp;
      set_mem(8'h25, 8'hDA, 8'h9C, 1'b0, 1'b0);
      apply_reset();
      run_load(-1, 0, -1, cyc);
      tests_run++;
      if (cyc !== 98) begin
         tests_failed++;
         $display("FAIL pu_done_latency: got %0d cycles, expected 98", cyc);
      end
      tests_run++;
      if ({op, op_n, tr, err} !== {6'h25, 4'hA, 8'h9C, 1'b0}) begin
         tests_failed++;
         $display("FAIL pu_values: got op=%h op_n=%h tr=%h err=%b, expected 25/a/9c/0",
                  op, op_n, tr, err);
      end
      tests_run++;
      if (rd_low !== 2) begin
         tests_failed++;
         $display("FAIL pu_rd_en_low: got %0d cycles, expected 2", rd_low);
      end
      errs = 0;
      if (strobe_log.size() != 24) errs++;
      else
         for (int k = 0; k < 24; k++) begin
            exp = {BASE + 15'(k / 8), 3'(k % 8)};
            if (strobe_log[k] !== exp) errs++;
         end
      tests_run++;
      if (errs !== 0) begin
         tests_failed++;
         $display("FAIL pu_strobe_order: %0d bad entries in %0d strobes, expected 0 in 24",
                  errs, strobe_log.size());
      end
   endtask

   task automatic test_corrupt_all();
      int cyc;
      set_mem(8'h25, 8'hDA, 8'h9C, 1'b0, 1'b1);
      apply_reset();
      run_load(-1, 0, -1, cyc);
      tests_run++;
      if (pulse_cnt !== 72 || cyc !== 1 + 97 * (MAX_RETRY + 1)) begin
         tests_failed++;
         $display("FAIL bad_all_timing: got %0d strobes %0d cycles, expected 72 strobes %0d",
                  pulse_cnt, cyc, 1 + 97 * (MAX_RETRY + 1));
      end
      tests_run++;
      if ({op, op_n, tr, err, done} !== {6'h00, 4'hF, 8'h80, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL bad_all_values: got op=%h op_n=%h tr=%h err=%b done=%b, expected 00/f/80/1/1",
                  op, op_n, tr, err, done);
      end
   endtask

   task automatic test_corrupt_first();
      int cyc;
      set_mem(8'h25, 8'hDA, 8'h9C, 1'b1, 1'b0);
      apply_reset();
      run_load(-1, 0, -1, cyc);
      tests_run++;
      if (pulse_cnt !== 48 || cyc !== 1 + 97 * 2) begin
         tests_failed++;
         $display("FAIL retry_once_timing: got %0d strobes %0d cycles, expected 48 strobes 195",
                  pulse_cnt, cyc);
      end
      tests_run++;
      if ({op, op_n, tr, err} !== {6'h25, 4'hA, 8'h9C, 1'b0}) begin
         tests_failed++;
         $display("FAIL retry_once_values: got op=%h op_n=%h tr=%h err=%b, expected 25/a/9c/0",
                  op, op_n, tr, err);
      end
   endtask

   task automatic test_busy_stall();
      int cyc;
      set_mem(8'h2D, 8'hD2, 8'h9C, 1'b0, 1'b0);
      apply_reset();
      // Raise busy during the final strobe cycle of bit 3 and hold it 20 cycles past the strobe
      run_load(16, 20, -1, cyc);
      tests_run++;
      if (cyc !== 118) begin
         tests_failed++;
         $display("FAIL busy_latency: got %0d cycles, expected 118", cyc);
      end
      tests_run++;
      if (rd_low !== 22) begin
         tests_failed++;
         $display("FAIL busy_rd_en_low: got %0d cycles, expected 22", rd_low);
      end
      tests_run++;
      if ({op, op_n, tr, err} !== {6'h2D, 4'h2, 8'h9C, 1'b0}) begin
         tests_failed++;
         $display("FAIL busy_values: got op=%h op_n=%h tr=%h err=%b, expected 2d/2/9c/0",
                  op, op_n, tr, err);
      end
   endtask

   task automatic test_reload();
      int   cyc;
      logic seen;
      set_mem(8'h25, 8'hDA, 8'h9C, 1'b0, 1'b0);
      apply_reset();
      run_load(-1, 0, -1, cyc);
      mem[2] = 8'h11;
      repeat (3) @(posedge clk);
      #1;
      cfg_reload = 1'b1;
      @(posedge clk);
      #1;
      cfg_reload = 1'b0;
      tests_run++;
      if ({done, tr} !== {1'b0, 8'h9C}) begin
         tests_failed++;
         $display("FAIL reload_start: got done=%b tr=%h, expected 0/9c", done, tr);
      end
      seen = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
         @(posedge clk);
         #1;
         seen = done;
      end
      tests_run++;
      if (seen !== 1'b1) begin
         tests_failed++;
         $display("FAIL reload_timeout: got done=%b after 400 cycles, expected 1", seen);
      end
      tests_run++;
      if ({op, tr, err} !== {6'h25, 8'h11, 1'b0}) begin
         tests_failed++;
         $display("FAIL reload_values: got op=%h tr=%h err=%b, expected 25/11/0", op, tr, err);
      end
   endtask

   task automatic test_reset_mid_load();
      int   cyc;
      logic hit;
      set_mem(8'h25, 8'hDA, 8'h9C, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      hit = 1'b0;
      for (int n = 0; n < 200 && !hit; n++) begin
         @(posedge clk);
         #1;
         hit = rd_clk && (ee_addr == BASE1) && (bit_sel == 3'd2);
      end
      tests_run++;
      if (hit !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_reach_byte1: got %b, expected 1", hit);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if ({op, op_n, tr, done, err, rd_en, rd_clk, ee_addr, bit_sel} !==
          {6'h00, 4'hF, 8'h80, 4'b0000, 15'h0, 3'h0}) begin
         tests_failed++;
         $display("FAIL midrst_values: got op=%h op_n=%h tr=%h flags=%b addr=%h bit=%0d, expected reset values",
                  op, op_n, tr, {done, err, rd_en, rd_clk}, ee_addr, bit_sel);
      end
      run_load(-1, 0, -1, cyc);
      tests_run++;
      if (cyc !== 98 || {op, op_n, tr, err} !== {6'h25, 4'hA, 8'h9C, 1'b0}) begin
         tests_failed++;
         $display("FAIL midrst_reload: got %0d cycles op=%h op_n=%h tr=%h err=%b, expected 98 25/a/9c/0",
                  cyc, op, op_n, tr, err);
      end
   endtask

   task automatic test_random();
      int         cyc, mode, attempts, exp_cyc;
      logic       pass;
      logic [7:0] b0, b1, b2, seen;
      logic [5:0] e_op;
      logic [3:0] e_opn;
      logic [7:0] e_tr;
      for (int t = 0; t < 8; t++) begin
         mode = $urandom_range(0, 3);
         b0 = 8'($urandom);
         b2 = 8'($urandom);
         b1 = (mode == 3) ? 8'($urandom) : ~b0;
         set_mem(b0, b1, b2, mode == 1, mode == 2);
         // Reference: each attempt reads all three bytes; succeed on first matching complement
         pass = 1'b0;
         attempts = 0;
         for (int a = 0; a <= MAX_RETRY; a++) begin
            if (!pass) begin
               attempts++;
               seen = (mode == 2 || (mode == 1 && a == 0)) ? 8'h00 : b1;
               if (seen == ~b0) pass = 1'b1;
            end
         end
         e_op    = pass ? b0[5:0] : 6'h00;
         e_opn   = pass ? ~b0[3:0] : 4'hF;
         e_tr    = pass ? b2 : 8'h80;
         exp_cyc = 1 + 97 * attempts;
         apply_reset();
         run_load(-1, 0, int'($urandom_range(5, 90)), cyc);
         tests_run++;
         if (cyc !== exp_cyc) begin
            tests_failed++;
            $display("FAIL rand%0d_cycles: got %0d, expected %0d (bytes %h/%h/%h mode %0d)",
                     t, cyc, exp_cyc, b0, b1, b2, mode);
         end
         tests_run++;
         if ({op, op_n, tr, err} !== {e_op, e_opn, e_tr, ~pass}) begin
            tests_failed++;
            $display("FAIL rand%0d_values: got op=%h op_n=%h tr=%h err=%b, expected %h/%h/%h/%b",
                     t, op, op_n, tr, err, e_op, e_opn, e_tr, ~pass);
         end
      end
   endtask

   initial begin
      mem[0] = 8'h00;
      mem[1] = 8'h00;
      mem[2] = 8'h00;
      test_reset();
      test_power_up();
      test_corrupt_all();
      test_corrupt_first();
      test_busy_stall();
      test_reload();
      test_reset_mid_load();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
